// File: rtl/param_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : param_dp_pkg
// Purpose  : Shared definitions for the parameterised datapath: operation
//            encodings, controller state encoding and flag bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package param_dp_pkg;

    // Operation encodings (4-bit op field). Codes 0xA..0xF are undefined.
    localparam logic [3:0] c_op_add  = 4'h0;
    localparam logic [3:0] c_op_addc = 4'h1;
    localparam logic [3:0] c_op_sub  = 4'h2;
    localparam logic [3:0] c_op_cmp  = 4'h3;
    localparam logic [3:0] c_op_and  = 4'h4;
    localparam logic [3:0] c_op_or   = 4'h5;
    localparam logic [3:0] c_op_xor  = 4'h6;
    localparam logic [3:0] c_op_mov  = 4'h7;
    localparam logic [3:0] c_op_load = 4'h8;
    localparam logic [3:0] c_op_stor = 4'h9;

    // Controller states
    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_exec = 2'd1,
        c_st_mem  = 2'd2,
        c_st_wb   = 2'd3
    } state_t;

    // Flag vector layout {C, L, F, Z, N}
    localparam int c_flag_c = 4;
    localparam int c_flag_l = 3;
    localparam int c_flag_f = 2;
    localparam int c_flag_z = 1;
    localparam int c_flag_n = 0;

    // Memory ops take the MEM path instead of EXEC.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == c_op_load) || (op == c_op_stor);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : dp_regfile
// Purpose  : NREGS x DATA_W register file, two combinational read ports plus
//            a combinational debug read port, one synchronous write port and
//            an asynchronous clear.
// Ports    : clk, rst            - clock, async active-high clear
//            i_ra_idx/o_ra_data  - read port A (destination operand)
//            i_rb_idx/o_rb_data  - read port B (source operand)
//            i_dbg_idx/o_dbg_data- debug read port
//            i_we/i_wr_idx/i_wr_data - write port
// Revision : 1.0 - initial release
// ============================================================================
module dp_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] i_ra_idx,
    output logic [DATA_W-1:0]        o_ra_data,
    input  logic [$clog2(NREGS)-1:0] i_rb_idx,
    output logic [DATA_W-1:0]        o_rb_data,
    input  logic [$clog2(NREGS)-1:0] i_dbg_idx,
    output logic [DATA_W-1:0]        o_dbg_data,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_wr_idx,
    input  logic [DATA_W-1:0]        i_wr_data
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wr_idx] <= i_wr_data;
        end
    end

    // Reads see the pre-write value, so rdest == rsrc uses the old contents.
    assign o_ra_data  = r_regs[i_ra_idx];
    assign o_rb_data  = r_regs[i_rb_idx];
    assign o_dbg_data = r_regs[i_dbg_idx];

endmodule
`default_nettype wire

// File: rtl/param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Purpose  : Multi-cycle register/ALU/memory datapath. Accepts one
//            instruction at a time through a valid/ready handshake, executes
//            ALU ops in one EXEC cycle, STOR in one MEM cycle and LOAD in
//            MEM + WB, with an inferred synchronous data memory.
// Ports    : clk, reset (async, active-high)
//            instr_valid/instr_ready, op, rdest, rsrc, imm_en, imm, flags_en
//            done, result, flags {C,L,F,Z,N}, err
//            dbg_idx/dbg_data - combinational register read for test
// Revision : 1.0 - initial release
// ============================================================================
module param_datapath
    import param_dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [3:0]               op,
    input  logic [$clog2(NREGS)-1:0] rdest,
    input  logic [$clog2(NREGS)-1:0] rsrc,
    input  logic                     imm_en,
    input  logic [7:0]               imm,
    input  logic                     flags_en,
    output logic                     done,
    output logic [DATA_W-1:0]        result,
    output logic [4:0]               flags,
    output logic                     err,
    input  logic [$clog2(NREGS)-1:0] dbg_idx,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int RIDX_W  = $clog2(NREGS);
    localparam int c_depth = 2 ** ADDR_W;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_op;
    logic [RIDX_W-1:0]   r_rdest, r_rsrc;
    logic                r_imm_en, r_flags_en;
    logic [7:0]          r_imm;
    logic [4:0]          r_flags;

    logic [DATA_W-1:0]   w_dest, w_src_reg, w_src;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_c, w_f, w_is_alu, w_alu_wr;
    logic [4:0]          w_flags_nxt;
    logic                w_rf_we, w_flags_we, w_mem_we;
    logic [DATA_W-1:0]   w_rf_wdata;
    logic [ADDR_W-1:0]   w_addr;

    logic [DATA_W-1:0]   r_mem [c_depth];
    logic [DATA_W-1:0]   r_mem_q;

    dp_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (reset),
        .i_ra_idx   (r_rdest),
        .o_ra_data  (w_dest),
        .i_rb_idx   (r_rsrc),
        .o_rb_data  (w_src_reg),
        .i_dbg_idx  (dbg_idx),
        .o_dbg_data (dbg_data),
        .i_we       (w_rf_we),
        .i_wr_idx   (r_rdest),
        .i_wr_data  (w_rf_wdata)
    );

    assign w_src  = r_imm_en ? {{(DATA_W-8){r_imm[7]}}, r_imm} : w_src_reg;
    // Upper source bits are dropped so addresses wrap around the memory.
    assign w_addr = w_src[ADDR_W-1:0];

    // Instruction latch: fields are frozen from acceptance until done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_rdest    <= '0;
            r_rsrc     <= '0;
            r_imm_en   <= 1'b0;
            r_imm      <= '0;
            r_flags_en <= 1'b0;
        end else if (instr_ready && instr_valid) begin
            r_op       <= op;
            r_rdest    <= rdest;
            r_rsrc     <= rsrc;
            r_imm_en   <= imm_en;
            r_imm      <= imm;
            r_flags_en <= flags_en;
        end
    end

    // ALU: borrow for SUB/CMP is the top bit of the (DATA_W+1)-bit difference.
    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_c       = 1'b0;
        w_f       = 1'b0;
        w_is_alu  = 1'b1;
        w_alu_wr  = 1'b1;
        case (r_op)
            c_op_add, c_op_addc: begin
                w_sum     = {1'b0, w_dest} + {1'b0, w_src}
                          + {{DATA_W{1'b0}}, (r_op == c_op_addc) & r_flags[c_flag_c]};
                w_alu_res = w_sum[DATA_W-1:0];
                w_c       = w_sum[DATA_W];
                w_f       = (w_dest[DATA_W-1] == w_src[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != w_dest[DATA_W-1]);
            end
            c_op_sub, c_op_cmp: begin
                w_sum     = {1'b0, w_dest} - {1'b0, w_src};
                w_alu_res = w_sum[DATA_W-1:0];
                w_c       = w_sum[DATA_W];
                w_f       = (w_dest[DATA_W-1] != w_src[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != w_dest[DATA_W-1]);
                w_alu_wr  = (r_op != c_op_cmp);
            end
            c_op_and: w_alu_res = w_dest & w_src;
            c_op_or:  w_alu_res = w_dest | w_src;
            c_op_xor: w_alu_res = w_dest ^ w_src;
            c_op_mov: w_alu_res = w_src;
            default: begin
                w_is_alu = 1'b0;
                w_alu_wr = 1'b0;
            end
        endcase
    end

    assign w_flags_nxt = {w_c, (w_dest < w_src), w_f, (w_alu_res == '0), w_alu_res[DATA_W-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        result      = '0;
        w_rf_we     = 1'b0;
        w_rf_wdata  = w_alu_res;
        w_flags_we  = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            c_st_idle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = is_mem_op(op) ? c_st_mem : c_st_exec;
                end
            end
            c_st_exec: begin
                done        = 1'b1;
                err         = ~w_is_alu;
                w_rf_we     = w_alu_wr;
                result      = w_alu_wr ? w_alu_res : '0;
                w_flags_we  = r_flags_en & w_is_alu;
                w_state_nxt = c_st_idle;
            end
            c_st_mem: begin
                if (r_op == c_op_load) begin
                    w_state_nxt = c_st_wb;
                end else begin
                    done        = 1'b1;
                    w_mem_we    = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wb: begin
                done        = 1'b1;
                w_rf_we     = 1'b1;
                w_rf_wdata  = r_mem_q;
                result      = r_mem_q;
                w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_flags_we) begin
            r_flags <= w_flags_nxt;
        end
    end

    assign flags = r_flags;

    // Single-port RAM with registered read data; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_addr] <= w_dest;
        end
        r_mem_q <= r_mem[w_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_datapath
// Purpose  : Self-checking bench for param_datapath: an instruction-level
//            reference model compared against the DUT every cycle, directed
//            scenarios with literal expectations, a randomized phase, and a
//            32-bit / 8-register build running the MOV/ADD scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_datapath;
    import param_dp_pkg::*;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int RW = 4;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    logic          instr_valid = 1'b0;
    logic [3:0]    op = '0;
    logic [RW-1:0] rdest = '0, rsrc = '0, dbg_idx = '0;
    logic          imm_en = 1'b0, flags_en = 1'b0;
    logic [7:0]    imm = '0;
    logic          instr_ready, done, err;
    logic [DW-1:0] result, dbg_data;
    logic [4:0]    flags;

    param_datapath #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) u_dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rdest(rdest), .rsrc(rsrc), .imm_en(imm_en), .imm(imm),
        .flags_en(flags_en), .done(done), .result(result), .flags(flags), .err(err),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    // 32-bit, 8-register build
    logic        v32 = 1'b0, ie32 = 1'b0, fe32 = 1'b0;
    logic [3:0]  op32 = '0;
    logic [2:0]  rd32 = '0, rs32 = '0, dbg32 = '0;
    logic [7:0]  imm32 = '0;
    logic        ready32, done32, err32;
    logic [31:0] res32, dbgd32;
    logic [4:0]  flags32;

    param_datapath #(.DATA_W(32), .NREGS(8), .ADDR_W(AW)) u_dut32 (
        .clk(clk), .reset(reset), .instr_valid(v32), .instr_ready(ready32),
        .op(op32), .rdest(rd32), .rsrc(rs32), .imm_en(ie32), .imm(imm32),
        .flags_en(fe32), .done(done32), .result(res32), .flags(flags32), .err(err32),
        .dbg_idx(dbg32), .dbg_data(dbgd32)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    logic [DW-1:0] mregs [NR];
    logic [DW-1:0] mmem  [1 << AW];
    logic [4:0]    mflags = '0;
    int            cl = 0;          // cycles left in the current instruction
    logic [3:0]    p_op = '0;
    logic [RW-1:0] p_rd = '0, p_rs = '0;
    logic          p_ie = 1'b0, p_fe = 1'b0;
    logic [7:0]    p_imm = '0;
    bit            chk_en = 1'b0;

    function automatic void eval(output logic wr, output logic [DW-1:0] res,
                                 output logic [4:0] nf, output logic upd,
                                 output logic bad, output logic [AW-1:0] addr);
        logic [DW-1:0] d, s;
        longint unsigned du, su, m, cin;
        longint sd, ss, sv, smax, smin;
        logic c, f;
        d    = mregs[p_rd];
        s    = p_ie ? {{(DW-8){p_imm[7]}}, p_imm} : mregs[p_rs];
        addr = s[AW-1:0];
        du = 64'(d); su = 64'(s); m = 64'(1) << DW;
        sd = $signed(d); ss = $signed(s);
        smax = (longint'(1) <<< (DW-1)) - 1;
        smin = -(longint'(1) <<< (DW-1));
        cin = 0; sv = 0;
        wr = 1'b1; upd = p_fe; bad = 1'b0; c = 1'b0; f = 1'b0; res = '0;
        case (p_op)
            c_op_add, c_op_addc: begin
                cin = (p_op == c_op_addc) ? 64'(mflags[4]) : 64'd0;
                res = DW'((du + su + cin) % m);
                c   = (du + su + cin) >= m;
                sv  = sd + ss + longint'(cin);
                f   = (sv > smax) || (sv < smin);
            end
            c_op_sub, c_op_cmp: begin
                res = DW'((du + m - su) % m);
                c   = du < su;
                sv  = sd - ss;
                f   = (sv > smax) || (sv < smin);
                wr  = (p_op == c_op_sub);
            end
            c_op_and: res = d & s;
            c_op_or:  res = d | s;
            c_op_xor: res = d ^ s;
            c_op_mov: res = s;
            c_op_load: begin res = mmem[addr]; upd = 1'b0; end
            c_op_stor: begin wr = 1'b0; upd = 1'b0; end
            default:   begin wr = 1'b0; upd = 1'b0; bad = 1'b1; end
        endcase
        nf = {c, du < su, f, res == '0, res[DW-1]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) mregs[i] = '0;
            mflags = '0;
            cl = 0;
        end else if (cl == 1) begin
            logic wr, upd, bad;
            logic [DW-1:0] r;
            logic [4:0] nf;
            logic [AW-1:0] a;
            eval(wr, r, nf, upd, bad, a);
            if (p_op == c_op_stor) mmem[a] = mregs[p_rd];
            if (wr) mregs[p_rd] = r;
            if (upd) mflags = nf;
            cl = 0;
        end else if (cl == 2) begin
            cl = 1;
        end else if (instr_valid) begin
            p_op = op; p_rd = rdest; p_rs = rsrc; p_ie = imm_en; p_imm = imm; p_fe = flags_en;
            cl = (op == c_op_load) ? 2 : 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic wr, upd, bad;
            logic [DW-1:0] r;
            logic [4:0] nf;
            logic [AW-1:0] a;
            eval(wr, r, nf, upd, bad, a);
            chk("ready",  instr_ready, cl == 0);
            chk("done",   done, cl == 1);
            chk("err",    err, (cl == 1) && bad);
            chk("result", result, (cl == 1 && wr) ? r : '0);
            chk("flags",  flags, mflags);
            chk("dbg",    dbg_data, mregs[dbg_idx]);
        end
    end

    // ---------------- directed helpers ----------------
    // Inputs only change at posedge+2 so sampling on negedge is race-free.
    task automatic issue(input logic [3:0] o, input int rd, input int rs,
                         input logic ie, input logic [7:0] im, input logic fe);
        int n = 0;
        op = o; rdest = RW'(rd); rsrc = RW'(rs); imm_en = ie; imm = im; flags_en = fe;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_wait", instr_ready, 1'b1);
        @(posedge clk); #2;
        instr_valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        chk("idle_wait", instr_ready, 1'b1);
        @(posedge clk); #2;
    endtask

    task automatic rd_chk(input string name, input int idx, input logic [DW-1:0] exp);
        dbg_idx = RW'(idx);
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic set_reg(input int r, input logic [DW-1:0] v);
        issue(c_op_mov, r, 0, 1'b1, 8'h00, 1'b0);
        for (int b = DW - 1; b >= 0; b--) begin
            issue(c_op_add, r, r, 1'b0, 8'h00, 1'b0);
            if (v[b]) issue(c_op_add, r, 0, 1'b1, 8'h01, 1'b0);
        end
        settle();
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mmem[i] = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #2;

        // Reset state
        chk("rst_ready",  instr_ready, 1'b1);
        chk("rst_done",   done, 1'b0);
        chk("rst_err",    err, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_flags",  flags, 5'b00000);

        // 32-bit build: MOV r1,#0x7F ; ADD r1,r1 with flags
        v32 = 1'b1; op32 = c_op_mov; rd32 = 3'd1; rs32 = 3'd0; ie32 = 1'b1; imm32 = 8'h7F; fe32 = 1'b0;
        @(negedge clk); chk("w32_ready0", ready32, 1'b1);
        @(posedge clk); #2; v32 = 1'b0;
        @(negedge clk); chk("w32_mov_done", done32, 1'b1); chk("w32_mov_res", res32, 32'h7F);
        @(posedge clk); #2;
        v32 = 1'b1; op32 = c_op_add; rd32 = 3'd1; rs32 = 3'd1; ie32 = 1'b0; fe32 = 1'b1;
        @(negedge clk); chk("w32_ready1", ready32, 1'b1);
        @(posedge clk); #2; v32 = 1'b0;
        @(negedge clk); chk("w32_add_done", done32, 1'b1); chk("w32_add_res", res32, 32'hFE);
        @(posedge clk); #2;
        dbg32 = 3'd1; #1;
        chk("w32_r1", dbgd32, 32'h0000_00FE);
        chk("w32_flags", flags32, 5'b00000);
        chk("w32_err", err32, 1'b0);

        // Fill memory: mem[a] = a for every address
        for (int a = 0; a < (1 << AW); a++) begin
            issue(c_op_stor, 0, 0, 1'b0, 8'h00, 1'b0);
            issue(c_op_add, 0, 0, 1'b1, 8'h01, 1'b0);
        end
        settle();
        pulse_reset();
        rd_chk("r0_after_reset", 0, 16'h0000);

        // MOV r1,#0x7F ; ADD r1,r1 with flags
        issue(c_op_mov, 1, 0, 1'b1, 8'h7F, 1'b0);
        @(negedge clk); chk("mov_done_lat", done, 1'b1);
        settle();
        issue(c_op_add, 1, 1, 1'b0, 8'h00, 1'b1);
        @(negedge clk); chk("add_done_lat", done, 1'b1); chk("add_result", result, 16'h00FE);
        settle();
        rd_chk("r1_fe", 1, 16'h00FE);
        chk("add_flags", flags, 5'b00000);

        // Signed overflow, then same add without flag update
        set_reg(2, 16'h7FFF);
        issue(c_op_add, 2, 0, 1'b1, 8'h01, 1'b1); settle();
        rd_chk("r2_8000", 2, 16'h8000);
        chk("ovf_flags", flags, 5'b00101);
        issue(c_op_add, 2, 0, 1'b1, 8'h01, 1'b0); settle();
        rd_chk("r2_8001", 2, 16'h8001);
        chk("noflag_flags", flags, 5'b00101);

        // CMP 5 vs 9
        issue(c_op_mov, 3, 0, 1'b1, 8'h05, 1'b0);
        issue(c_op_mov, 4, 0, 1'b1, 8'h09, 1'b0);
        issue(c_op_cmp, 3, 4, 1'b0, 8'h00, 1'b1);
        @(negedge clk); chk("cmp_result", result, 16'h0000);
        settle();
        rd_chk("r3_keep", 3, 16'h0005);
        chk("cmp_flags", flags, 5'b11001);

        // STOR through aliased address 0x403, LOAD from 0x003
        set_reg(5, 16'h0403);
        set_reg(6, 16'hBEEF);
        issue(c_op_stor, 6, 5, 1'b0, 8'h00, 1'b0); settle();
        issue(c_op_load, 7, 0, 1'b1, 8'h03, 1'b0);
        @(negedge clk); chk("load_mem_done", done, 1'b0);
        @(negedge clk); chk("load_wb_done", done, 1'b1); chk("load_result", result, 16'hBEEF);
        settle();
        rd_chk("r7_beef", 7, 16'hBEEF);

        // Reset during MEM of a LOAD
        issue(c_op_load, 9, 0, 1'b1, 8'h03, 1'b0);
        #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
        @(negedge clk); chk("abort_ready", instr_ready, 1'b1);
        @(posedge clk); #2;
        rd_chk("r9_zero", 9, 16'h0000);
        issue(c_op_load, 10, 0, 1'b1, 8'h03, 1'b0); settle();
        rd_chk("mem_kept", 10, 16'hBEEF);

        // Undefined op
        issue(c_op_mov, 1, 0, 1'b1, 8'h11, 1'b0); settle();
        issue(4'hF, 1, 10, 1'b0, 8'h00, 1'b1);
        @(negedge clk); chk("undef_err", err, 1'b1); chk("undef_done", done, 1'b1);
        settle();
        rd_chk("undef_r1", 1, 16'h0011);
        for (int i = 0; i < NR; i++) begin
            dbg_idx = RW'(i); #1;
            chk("undef_regs", dbg_data, mregs[i]);
        end
        @(posedge clk); #2;

        // Randomized phase: inputs change every cycle, including while busy
        repeat (3000) begin
            instr_valid = ($urandom_range(0, 99) < 60);
            op          = 4'($urandom_range(0, 15));
            rdest       = RW'($urandom);
            rsrc        = RW'($urandom);
            imm_en      = 1'($urandom);
            imm         = 8'($urandom);
            flags_en    = 1'($urandom);
            dbg_idx     = RW'($urandom);
            @(posedge clk); #2;
        end
        instr_valid = 1'b0;
        settle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width (>= 8).
REQ-002 Parameter NREGS, default 16, register count (power of two, >= 2); RIDX_W = clog2(NREGS).
REQ-003 Parameter ADDR_W, default 10, data-memory address width; depth 2**ADDR_W words of DATA_W.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Ports instr_valid in 1 / instr_ready out 1: instruction handshake; transfer when both are high on a rising edge.
REQ-007 Port op  input  4  operation code, encodings from the shared package.
REQ-008 Ports rdest, rsrc  input  RIDX_W each  destination and source register indices.
REQ-009 Ports imm_en in 1 / imm in 8: use the sign-extended imm in place of Src.
REQ-010 Port flags_en  input  1  allow the flags register to update on this instruction.
REQ-011 Port done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-012 Port result  output  DATA_W  value being written back; valid while done is high, 0 otherwise.
REQ-013 Port flags  output  5  registered {C, L, F, Z, N}.
REQ-014 Port err  output  1  high with done when op is undefined.
REQ-015 Ports dbg_idx in RIDX_W / dbg_data out DATA_W: combinational register-file read for test.

Function
REQ-016 FSM states are IDLE, EXEC, MEM and WB; instr_ready is high only in IDLE.
REQ-017 On acceptance, op, rdest, rsrc, imm_en, imm and flags_en are latched; later port changes have no effect until done.
REQ-018 ALU ops (ADD, ADDC, SUB, CMP, AND, OR, XOR, MOV) go IDLE->EXEC->IDLE; done is high in EXEC; the write lands on the EXEC-exit edge; latency 2 cycles; throughput 1 per 2 cycles.
REQ-019 ADD/ADDC/SUB compute Dest op Src modulo 2**DATA_W; ADDC adds the stored C flag.
REQ-020 CMP computes Dest-Src for flags only and does not write back.
REQ-021 AND/OR/XOR are bitwise; MOV writes Src (or immediate) to rdest.
REQ-022 Flag rules: C = carry-out (ADD/ADDC) or borrow (SUB/CMP); L = unsigned Dest<Src; F = signed overflow; Z = result==0; N = result MSB; logic ops and MOV clear C and F.
REQ-023 Flags update only when flags_en is latched high, on the same edge as the write-back.
REQ-024 LOAD goes IDLE->MEM->WB->IDLE; the address is Src[ADDR_W-1:0] in MEM; memory data is registered; rdest is written at the WB-exit edge; done is high in WB; latency 3.
REQ-025 STOR goes IDLE->MEM->IDLE; mem[Src[ADDR_W-1:0]] <= Dest at the MEM-exit edge; done is high in MEM; no register or flag change.
REQ-026 Address bits of Src above ADDR_W are ignored, so addresses wrap.
REQ-027 An undefined op goes IDLE->EXEC->IDLE with done and err high; no register, flag or memory change.
REQ-028 When rdest equals rsrc, both operands are read before the write, so the old value is used.
REQ-029 instr_valid is ignored outside IDLE; a held-high valid is accepted on the edge leaving the final state only if ready is already high, which it is not, so the next acceptance occurs the following cycle.

Reset
REQ-030 Reset asynchronously forces IDLE, clears all registers and flags, and drives done=0, err=0, result=0 and instr_ready=1 after release.
REQ-031 Reset mid-instruction aborts it with no write-back; memory contents are not cleared.

Structure
REQ-032 The shared package param_dp_pkg holds op encodings, the state enum and flag bit positions (C=4, L=3, F=2, Z=1, N=0).
REQ-033 Sub-module dp_regfile (parameterised NREGS x DATA_W, two combinational read ports, one write port, async clear); memory is an inferred single-port synchronous RAM inside the top level.

Verification
REQ-034 After reset, MOV r1,#0x7F then ADD r1,r1 with flags_en -> r1=0x00FE, flags C=0, F=0, N=0, Z=0; done 2 cycles after each accept.
REQ-035 r2=0x7FFF, ADD r2,#1 with flags_en -> r2=0x8000, F=1, N=1, C=0; the same add with flags_en=0 leaves flags unchanged.
REQ-036 r3=5, r4=9, CMP r3,r4 -> r3 unchanged, L=1, C=1, Z=0, N=1.
REQ-037 r5=0x0403 (ADDR_W=10), STOR r6=0xBEEF to [r5], then LOAD r7 from [0x0003+0x400 alias] -> r7=0xBEEF; LOAD done 3 cycles after accept.
REQ-038 Reset asserted in MEM of a LOAD -> the target register stays 0 and instr_ready=1 on the cycle after release.
REQ-039 Undefined op 0xF -> err=1 with done, dbg read of all registers unchanged; NREGS=8, DATA_W=32 build repeats REQ-034.
